// File: rtl/tern_pkg.sv
// Shared types and encodings for the ternary dot-product sequencer.
//   trit_t        : 2-bit trit (00 = 0, 01 = +1, 11 = -1, 10 = illegal)
//   PROD_*        : lane product codes (00 = 0, 10 = +1, 01 = -1)
//   dotp_state_e  : sequencer FSM states
//   trit_mul      : single-lane ternary multiply; illegal operands give zero
package tern_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b11;
  localparam trit_t TRIT_ILL  = 2'b10;

  localparam logic [1:0] PROD_ZERO = 2'b00;
  localparam logic [1:0] PROD_POS  = 2'b10;
  localparam logic [1:0] PROD_NEG  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_OUT
  } dotp_state_e;

  function automatic logic [1:0] trit_mul(input trit_t a, input trit_t w);
    logic [1:0] p;
    p = PROD_ZERO;
    if (a == TRIT_ZERO || w == TRIT_ZERO || a == TRIT_ILL || w == TRIT_ILL) begin
      p = PROD_ZERO;
    end else if (a == w) begin
      p = PROD_POS;
    end else begin
      p = PROD_NEG;
    end
    return p;
  endfunction

endpackage

// File: rtl/tern_lane_popcount.sv
// Combinational ternary lane multiply and popcount.
//   act, weight : N_LANES packed trits, lane k at bits [2k+1:2k]
//   pos_cnt     : number of lanes whose product is +1
//   neg_cnt     : number of lanes whose product is -1
// Lanes with an illegal operand contribute to neither count.
module tern_lane_popcount
  import tern_pkg::*;
#(
  parameter  int unsigned N_LANES = 16,
  localparam int unsigned CNT_W   = $clog2(N_LANES + 1)
) (
  input  logic [2*N_LANES-1:0] act,
  input  logic [2*N_LANES-1:0] weight,
  output logic [CNT_W-1:0]     pos_cnt,
  output logic [CNT_W-1:0]     neg_cnt
);

  logic [1:0] prod;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    prod    = PROD_ZERO;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      prod = trit_mul(act[2*k +: 2], weight[2*k +: 2]);
      if (prod == PROD_POS) pos_cnt = pos_cnt + CNT_W'(1);
      if (prod == PROD_NEG) neg_cnt = neg_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tern_dotp_sequencer.sv
// Ternary dot-product sequencer: accumulates (pos - neg) lane popcounts over
// a configured number of beats and returns one signed result per transaction.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o   : transaction request (beat count cfg_beats_i,
//                               clamped to MAX_BEATS); ready only in IDLE
//   in_valid_i/in_ready_o     : beat stream act_i/weight_i; ready only in ACCUM
//   res_valid_o/res_ready_i   : result handshake, res_data_o signed sum
//   busy_o                    : high outside IDLE
//   res_err_o                 : (TERN_DOTP_ILLEGAL_CHECK_EN only) sticky flag,
//                               an accepted beat carried an illegal trit code
// Pipeline: beat -> stage-1 diff register -> accumulator. FLUSH drains stage 1.
module tern_dotp_sequencer
  import tern_pkg::*;
#(
  parameter  int unsigned N_LANES   = 16,
  parameter  int unsigned MAX_BEATS = 9,
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1),
  localparam int unsigned ACC_W     = $clog2(N_LANES * MAX_BEATS + 1) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [BEAT_W-1:0]       cfg_beats_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [2*N_LANES-1:0]    act_i,
  input  logic [2*N_LANES-1:0]    weight_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic signed [ACC_W-1:0] res_data_o,
  output logic                    busy_o
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
  ,
  output logic                    res_err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(N_LANES + 1);

  dotp_state_e state_q, state_d;

  logic [BEAT_W-1:0]       beats_q, cnt_q, beats_clamped;
  logic                    s1_valid_q;
  logic signed [CNT_W:0]   s1_diff_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        pos_cnt, neg_cnt;
  logic                    cfg_fire, beat_fire, last_beat;

  tern_lane_popcount #(
    .N_LANES (N_LANES)
  ) u_popcount (
    .act     (act_i),
    .weight  (weight_i),
    .pos_cnt (pos_cnt),
    .neg_cnt (neg_cnt)
  );

  always_comb begin
    beats_clamped = (cfg_beats_i > BEAT_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS) : cfg_beats_i;
    last_beat     = ((cnt_q + BEAT_W'(1)) == beats_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = 1'b1;
    cfg_fire    = 1'b0;
    beat_fire   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i) begin
          cfg_fire = 1'b1;
          state_d  = (beats_clamped == '0) ? ST_FLUSH : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          beat_fire = 1'b1;
          if (last_beat) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_OUT;
      ST_OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_q    <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= beat_fire;
      if (beat_fire) begin
        s1_diff_q <= $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
        cnt_q     <= cnt_q + BEAT_W'(1);
      end
      if (cfg_fire) begin
        beats_q <= beats_clamped;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else if (s1_valid_q) begin
        acc_q <= acc_q + ACC_W'(s1_diff_q);
      end
    end
  end

  // Result is forced to zero outside OUT so reset and idle values are clean.
  assign res_data_o = (state_q == ST_OUT) ? acc_q : '0;

`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
  logic err_q, beat_illegal;

  always_comb begin
    beat_illegal = 1'b0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (act_i[2*k +: 2] == TRIT_ILL || weight_i[2*k +: 2] == TRIT_ILL) beat_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                          err_q <= 1'b0;
    else if (cfg_fire)                  err_q <= 1'b0;
    else if (beat_fire && beat_illegal) err_q <= 1'b1;
  end

  assign res_err_o = err_q;
`else
  // Illegal lanes are zeroed inside the popcount; no flag is kept.
`endif

endmodule

// File: tb/tb_tern_dotp_sequencer.sv
// Testbench for tern_dotp_sequencer: directed and randomized transactions
// checked against an integer-arithmetic reference of the ternary dot product.
module tb_tern_dotp_sequencer;

  localparam int N  = 16;
  localparam int MB = 9;
  localparam int BW = 4;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [BW-1:0] cfg_beats = '0;
  logic [2*N-1:0] act = '0;
  logic [2*N-1:0] wt = '0;
  logic cfg_ready, in_ready, res_valid, busy;
  logic signed [AW-1:0] res_data;
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
  logic res_err;
`endif

  always #5 clk = ~clk;

  tern_dotp_sequencer #(
    .N_LANES   (N),
    .MAX_BEATS (MB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_beats_i (cfg_beats),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .act_i       (act),
    .weight_i    (wt),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .busy_o      (busy)
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
    ,
    .res_err_o   (res_err)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [2*N-1:0] beat_act [MB];
  logic [2*N-1:0] beat_wt  [MB];
  logic signed [31:0] last_res;
  logic last_err;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int trit_value(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_dot(input logic [2*N-1:0] a, input logic [2*N-1:0] w);
    int s;
    logic [1:0] ta, tw;
    s = 0;
    for (int k = 0; k < N; k++) begin
      ta = a[2*k +: 2];
      tw = w[2*k +: 2];
      if (ta != 2'b10 && tw != 2'b10) s += trit_value(ta) * trit_value(tw);
    end
    return s;
  endfunction

  function automatic bit ref_ill(input logic [2*N-1:0] a, input logic [2*N-1:0] w);
    bit f;
    f = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (a[2*k +: 2] == 2'b10 || w[2*k +: 2] == 2'b10) f = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [2*N-1:0] rand_vec(input int ill_pct);
    logic [2*N-1:0] v;
    int r;
    v = '0;
    for (int k = 0; k < N; k++) begin
      r = int'($urandom_range(0, 2));
      if (int'($urandom_range(0, 99)) < ill_pct) v[2*k +: 2] = 2'b10;
      else if (r == 0)                           v[2*k +: 2] = 2'b00;
      else if (r == 1)                           v[2*k +: 2] = 2'b01;
      else                                       v[2*k +: 2] = 2'b11;
    end
    return v;
  endfunction

  // Beat slot idx: p lanes of (+1)(+1), n lanes of (+1)(-1), rest weighted by zero.
  task automatic build_mixed(input int idx, input int p, input int n);
    logic [2*N-1:0] a, w;
    for (int k = 0; k < N; k++) begin
      if (k < p) begin
        a[2*k +: 2] = 2'b01; w[2*k +: 2] = 2'b01;
      end else if (k < p + n) begin
        a[2*k +: 2] = 2'b01; w[2*k +: 2] = 2'b11;
      end else begin
        a[2*k +: 2] = 2'b11; w[2*k +: 2] = 2'b00;
      end
    end
    beat_act[idx] = a;
    beat_wt[idx]  = w;
  endtask

  // One full transaction from the cfg handshake to result consumption.
  task automatic run_txn(input int nb, input int bubble_pct, input int hold);
    int eff, expv, last_edge, guard;
    bit exp_err, taken;
    last_res = 'x;
    last_err = 1'bx;
    eff = (nb > MB) ? MB : nb;
    expv = 0;
    exp_err = 1'b0;
    check("cfg_ready_idle", cfg_ready, 1);
    check("busy_idle", busy, 0);
    cfg_valid = 1'b1;
    cfg_beats = BW'(nb);
    tick();
    cfg_valid = 1'b0;
    last_edge = cyc;
    for (int b = 0; b < eff; b++) begin
      taken = 1'b0;
      guard = 0;
      act = beat_act[b];
      wt  = beat_wt[b];
      while (!taken && guard < 64) begin
        in_valid = (int'($urandom_range(0, 99)) >= bubble_pct);
        taken = in_valid && in_ready;
        tick();
        guard++;
      end
      in_valid = 1'b0;
      if (!taken) begin
        check("beat_accept", taken, 1);
        return;
      end
      expv += ref_dot(beat_act[b], beat_wt[b]);
      exp_err |= ref_ill(beat_act[b], beat_wt[b]);
      last_edge = cyc;
    end
    guard = 0;
    while (!res_valid && guard < 8) begin
      check("in_ready_after_last", in_ready, 0);
      tick();
      guard++;
    end
    check("res_valid_rise", res_valid, 1);
    // Valid in the second cycle after the accepting edge: one further edge.
    check("result_latency_edges", cyc - last_edge, 1);
    if (!res_valid) return;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_beats = BW'($urandom_range(0, 15));
      in_valid  = 1'($urandom_range(0, 1));
      check("hold_res_data", res_data, expv);
      check("hold_res_valid", res_valid, 1);
      check("hold_cfg_ready", cfg_ready, 0);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    check("res_data", res_data, expv);
    check("busy_out", busy, 1);
    last_res = res_data;
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
    check("res_err", res_err, exp_err);
    last_err = res_err;
`endif
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("cfg_ready_back", cfg_ready, 1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single beat, all +1 * +1
    beat_act[0] = {N{2'b01}};
    beat_wt[0]  = {N{2'b01}};
    run_txn(1, 0, 0);
    check("t1_value", last_res, 16);

    // Full-length all -1 * +1: most negative result
    for (int b = 0; b < MB; b++) begin
      beat_act[b] = {N{2'b11}};
      beat_wt[b]  = {N{2'b01}};
    end
    run_txn(9, 0, 0);
    check("t2_value", last_res, -144);

    // Mixed beats +5, -2, 0 with bubbles and a stalled consumer
    build_mixed(0, 6, 1);
    build_mixed(1, 1, 3);
    build_mixed(2, 2, 2);
    run_txn(3, 40, 4);
    check("t3_value", last_res, 3);

    // Zero-beat transaction
    run_txn(0, 0, 2);
    check("t4_value", last_res, 0);

    // Reset in the middle of a 5-beat transaction
    cfg_valid = 1'b1;
    cfg_beats = BW'(5);
    tick();
    cfg_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      act = rand_vec(0);
      wt  = rand_vec(0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    build_mixed(0, 3, 0);
    run_txn(1, 0, 1);
    check("t5_value", last_res, 3);

    // Illegal activation code on lane 0; other lanes weighted by zero
    beat_act[0] = {N{2'b01}};
    beat_act[0][1:0] = 2'b10;
    beat_wt[0] = '0;
    beat_wt[0][1:0] = 2'b01;
    run_txn(1, 0, 0);
    check("t6_value", last_res, 0);
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
    check("t6_err_set", last_err, 1);
`endif
    build_mixed(0, 2, 0);
    run_txn(1, 0, 0);
    check("t6_clean_value", last_res, 2);
`ifdef TERN_DOTP_ILLEGAL_CHECK_EN
    check("t6_err_clear", last_err, 0);
`endif

    // Randomized transactions, including over-range beat counts and illegal codes
    for (int t = 0; t < 16; t++) begin
      for (int b = 0; b < MB; b++) begin
        beat_act[b] = rand_vec(4);
        beat_wt[b]  = rand_vec(4);
      end
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 50)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
